// File: rtl/sram_mem_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared types and defaults for the SRAM data-memory controller
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Wait counter width; holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15
    localparam int CNT_WIDTH           = 4;
    localparam int BASE_ADDR_DEFAULT   = 1024;
    localparam int DEPTH_WORDS_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OP_LOAD  = 1'b0,
        OP_STORE = 1'b1
    } op_t;

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/sram_mem_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_mem_controller_if
//  Description : MEM-stage request/response bus between pipeline and the
//                SRAM controller
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_mem_controller_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  rd_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  ready;
    logic                  addr_err;

    // Pipeline side: issues requests, observes results
    modport master (
        output rd_en, wr_en, address, write_data,
        input  read_data, ready, addr_err
    );

    // Controller side
    modport slave (
        input  rd_en, wr_en, address, write_data,
        output read_data, ready, addr_err
    );
endinterface : sram_mem_controller_if
`default_nettype wire

// File: rtl/sram_mem_controller_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_wait_counter
//  Description : Loadable down-counter timing the SRAM access window; the
//                zero flag marks the final access cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter
    import mem_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             load,
    input  wire logic             dec,
    input  wire logic [WIDTH-1:0] load_value,
    output logic                  zero
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority; decrement saturates at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule : sram_wait_counter
`default_nettype wire

// File: rtl/sram_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_mem_controller
//  Description : MEM-stage initiator for the data SRAM. Validates and latches
//                one load/store, holds SRAM enables for WAIT_CYCLES cycles,
//                returns registered read data and a pipeline-freeze ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT,
    parameter int WAIT_CYCLES = 5
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    sram_mem_controller_if.slave       bus,
    output logic                       sram_r_en,
    output logic                       sram_w_en,
    output logic [ADDR_WIDTH-1:0]      sram_address,
    output logic [DATA_WIDTH-1:0]      sram_write_data,
    input  wire logic [DATA_WIDTH-1:0] sram_read_data
);

    // Window bounds kept one bit wider than the address so a request near
    // the top of the address space cannot wrap into the window.
    localparam logic [ADDR_WIDTH:0]  c_win_lo = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]  c_win_hi = (ADDR_WIDTH+1)'(BASE_ADDR)
                                              + (ADDR_WIDTH+1)'(4 * DEPTH_WORDS);
    localparam logic [CNT_WIDTH-1:0] c_load   = CNT_WIDTH'(WAIT_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_read_data;
    op_t                   r_op;
    logic                  r_err;

    logic                  w_req;
    logic [ADDR_WIDTH:0]   w_addr_ext;
    logic                  w_valid;
    logic                  w_ready;
    logic                  w_sram_r_en;
    logic                  w_sram_w_en;
    logic                  w_cnt_load;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;
    logic                  w_capture;
    logic                  w_accept;

    assign w_req      = bus.rd_en | bus.wr_en;
    assign w_addr_ext = {1'b0, bus.address};
    assign w_valid    = (bus.address[1:0] == 2'b00)
                      && (w_addr_ext >= c_win_lo)
                      && (w_addr_ext <  c_win_hi);
    assign w_accept   = (r_state == IDLE) && w_req;

    sram_wait_counter #(
        .WIDTH      (CNT_WIDTH)
    ) u_wait_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_cnt_load),
        .dec        (w_cnt_dec),
        .load_value (c_load),
        .zero       (w_cnt_zero)
    );

    // State register; async reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, freeze and SRAM enable decode
    always_comb begin
        w_next      = r_state;
        w_ready     = 1'b0;
        w_sram_r_en = 1'b0;
        w_sram_w_en = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                // Freeze in the same cycle the request appears
                w_ready = ~w_req;
                if (w_req) begin
                    if (w_valid) begin
                        w_next     = ACCESS;
                        w_cnt_load = 1'b1;
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            ACCESS: begin
                w_sram_w_en = (r_op == OP_STORE);
                w_sram_r_en = (r_op == OP_LOAD);
                w_cnt_dec   = 1'b1;
                if (w_cnt_zero) begin
                    w_capture = (r_op == OP_LOAD);
                    w_next    = DONE;
                end
            end
            DONE: begin
                w_ready = 1'b1;
                w_next  = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Capture the request in IDLE; store wins when both enables are high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= OP_LOAD;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= bus.address;
            r_wdata <= bus.write_data;
            r_op    <= bus.wr_en ? OP_STORE : OP_LOAD;
            r_err   <= ~w_valid;
        end
    end

    // Read data: SRAM value on the last read cycle, cleared by a rejected
    // load, otherwise held (stores leave it untouched)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_data <= '0;
        end else if (w_capture) begin
            r_read_data <= sram_read_data;
        end else if (w_accept && !w_valid && !bus.wr_en) begin
            r_read_data <= '0;
        end
    end

    assign sram_r_en       = w_sram_r_en;
    assign sram_w_en       = w_sram_w_en;
    assign sram_address    = (r_state == ACCESS) ? r_addr  : '0;
    assign sram_write_data = (r_state == ACCESS) ? r_wdata : '0;

    assign bus.ready       = w_ready;
    assign bus.addr_err    = (r_state == DONE) && r_err;
    assign bus.read_data   = r_read_data;

endmodule : sram_mem_controller
`default_nettype wire
